// File: rtl/jk_ctl_pkg.sv
// Shared constants for the J/K command scheduler: command encodings,
// FSM states and helpers that map a command onto the J and K levels.
package jk_ctl_pkg;

    // Command encodings follow the jk_ff case order {J,K}.
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_CLR  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_TGL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // J level requested by a command.
    function automatic logic cmd_j(input logic [1:0] cmd);
        case (cmd)
            CMD_SET:  cmd_j = 1'b1;
            CMD_TGL:  cmd_j = 1'b1;
            CMD_HOLD: cmd_j = 1'b0;
            CMD_CLR:  cmd_j = 1'b0;
            default:  cmd_j = 1'b0;
        endcase
    endfunction

    // K level requested by a command.
    function automatic logic cmd_k(input logic [1:0] cmd);
        case (cmd)
            CMD_CLR:  cmd_k = 1'b1;
            CMD_TGL:  cmd_k = 1'b1;
            CMD_HOLD: cmd_k = 1'b0;
            CMD_SET:  cmd_k = 1'b0;
            default:  cmd_k = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_sched_rr_arbiter.sv
// Combinational round-robin pick: the first requester found searching
// upward from ptr+1 (modulo N) wins. The pointer register lives in the
// parent so this block stays stateless.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_id,
    output logic          any
);

    int best_dist_s;
    int best_id_s;
    int dist_s;

    // Rank each requester by its distance from ptr+1 and keep the nearest valid one.
    always_comb begin
        best_dist_s = N;
        best_id_s   = 0;
        dist_s      = 0;
        for (int k = 0; k < N; k++) begin
            dist_s = (k + N - 1 - int'(ptr)) % N;
            if (req[k] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                best_id_s   = k;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        any    = (best_dist_s < N);
        gnt_id = PW'(best_id_s);
        for (int k = 0; k < N; k++) begin
            gnt[k] = any && (k == best_id_s);
        end
    end

endmodule

// File: rtl/jk_cmd_sched.sv
// Round-robin scheduler sharing one jk_ff bank between several
// requesters. A granted command drives one-hot J/K levels for cnt+1
// cycles, then done pulses and the block returns to idle.
module jk_cmd_sched #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int CNT_W = 4,
    parameter int IDX_W = $clog2(NBITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_cmd,
    input  logic [IDX_W*NREQ-1:0]   req_idx,
    input  logic [CNT_W*NREQ-1:0]   req_cnt,
    output logic [NBITS-1:0]        jk_j,
    output logic [NBITS-1:0]        jk_k,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    done,
    output logic                    idx_err
);

    import jk_ctl_pkg::*;

    localparam int GW = $clog2(NREQ);

    // Control state
    state_e              state_r, state_nxt_s;
    logic [1:0]          cmd_r, cmd_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s;
    logic [CNT_W-1:0]    rcnt_r, rcnt_nxt_s;
    logic [GW-1:0]       ptr_r, ptr_nxt_s;
    logic [GW-1:0]       grant_id_r, gid_nxt_s;

    // Registered outputs
    logic [NBITS-1:0]    jk_j_r, jk_j_nxt_s;
    logic [NBITS-1:0]    jk_k_r, jk_k_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic                idx_err_r, idx_err_nxt_s;

    // Arbiter results and the winner's command fields
    logic [NREQ-1:0]     arb_gnt_s;
    logic [GW-1:0]       arb_id_s;
    logic                arb_any_s;
    logic [1:0]          cmd_sel_s;
    logic [IDX_W-1:0]    idx_sel_s;
    logic [CNT_W-1:0]    cnt_sel_s;
    logic                drive_nxt_s;
    logic                range_ok_s;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_r),
        .gnt    (arb_gnt_s),
        .gnt_id (arb_id_s),
        .any    (arb_any_s)
    );

    // Pull the winning requester's command, index and count out of the packed buses.
    always_comb begin
        cmd_sel_s = CMD_HOLD;
        idx_sel_s = {IDX_W{1'b0}};
        cnt_sel_s = {CNT_W{1'b0}};
        for (int r = 0; r < NREQ; r++) begin
            if (arb_gnt_s[r]) begin
                cmd_sel_s = req_cmd[2*r +: 2];
                idx_sel_s = req_idx[IDX_W*r +: IDX_W];
                cnt_sel_s = req_cnt[CNT_W*r +: CNT_W];
            end else begin
                cmd_sel_s = cmd_sel_s;
            end
        end
    end

    // Accept only while idle; the arbiter's one-hot pick is the ready vector.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready = arb_gnt_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Next-state logic: latch a command on handshake, count down while driving.
    always_comb begin
        state_nxt_s = state_r;
        cmd_nxt_s   = cmd_r;
        idx_nxt_s   = idx_r;
        rcnt_nxt_s  = rcnt_r;
        ptr_nxt_s   = ptr_r;
        gid_nxt_s   = grant_id_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_nxt_s = ST_DRIVE;
                    cmd_nxt_s   = cmd_sel_s;
                    idx_nxt_s   = idx_sel_s;
                    rcnt_nxt_s  = cnt_sel_s;
                    ptr_nxt_s   = arb_id_s;
                    gid_nxt_s   = arb_id_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (rcnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    rcnt_nxt_s = rcnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        drive_nxt_s   = (state_nxt_s == ST_DRIVE);
        range_ok_s    = (int'(idx_nxt_s) < NBITS);
        busy_nxt_s    = drive_nxt_s;
        done_nxt_s    = drive_nxt_s && (rcnt_nxt_s == {CNT_W{1'b0}});
        idx_err_nxt_s = done_nxt_s && !range_ok_s;
        for (int b = 0; b < NBITS; b++) begin
            jk_j_nxt_s[b] = drive_nxt_s && (int'(idx_nxt_s) == b) && cmd_j(cmd_nxt_s);
            jk_k_nxt_s[b] = drive_nxt_s && (int'(idx_nxt_s) == b) && cmd_k(cmd_nxt_s);
        end
    end

    // Control registers; reset discards any command in flight and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cmd_r      <= CMD_HOLD;
            idx_r      <= {IDX_W{1'b0}};
            rcnt_r     <= {CNT_W{1'b0}};
            ptr_r      <= GW'(NREQ - 1);
            grant_id_r <= {GW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            cmd_r      <= cmd_nxt_s;
            idx_r      <= idx_nxt_s;
            rcnt_r     <= rcnt_nxt_s;
            ptr_r      <= ptr_nxt_s;
            grant_id_r <= gid_nxt_s;
        end
    end

    // Output registers feeding the bank and status pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jk_j_r    <= {NBITS{1'b0}};
            jk_k_r    <= {NBITS{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            idx_err_r <= 1'b0;
        end else begin
            jk_j_r    <= jk_j_nxt_s;
            jk_k_r    <= jk_k_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            idx_err_r <= idx_err_nxt_s;
        end
    end

    assign jk_j     = jk_j_r;
    assign jk_k     = jk_k_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign idx_err  = idx_err_r;
    assign grant_id = grant_id_r;

endmodule
